// File: rtl/tmds_pkg.sv
// TMDS shared constants and types.
// Used by tmds_encode and tmds_decode_align.
package tmds_pkg;

  localparam int TMDS_W = 10;
  localparam int CNT_W  = 12;

  // Control tokens, indexed by {c1,c0}
  localparam logic [3:0][TMDS_W-1:0] TOKEN = {
    10'b1010101011,
    10'b0101010100,
    10'b0010101011,
    10'b1101010100
  };

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] sync;
    logic       de;
    logic       locked;
  } out_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// TMDS 10b symbol classifier and data decoder.
// Combinational; shared by all three channels.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_W-1:0] sym,
  output logic              is_token,
  output logic [1:0]        ctl,
  output logic [7:0]        data
);

  logic [7:0] p;

  always_comb begin
    is_token = 1'b1;
    ctl      = 2'd0;
    unique case (1'b1)
      sym == TOKEN[0]: ctl = 2'd0;
      sym == TOKEN[1]: ctl = 2'd1;
      sym == TOKEN[2]: ctl = 2'd2;
      sym == TOKEN[3]: ctl = 2'd3;
      default:         is_token = 1'b0;
    endcase
  end

  always_comb begin
    p = sym[9] ? ~sym[7:0] : sym[7:0];
    data[0] = p[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (p[i] ^ p[i-1])
                       : ~(p[i] ^ p[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decode_align.sv
// TMDS receive channel: bit-slip alignment
// on control-token runs, then 10b->8b decode.
module tmds_decode_align
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 12,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TMDS_W-1:0] sym_in,
  input  logic              resync,
  output logic [7:0]        d_out,
  output logic [1:0]        sync_out,
  output logic              de,
  output logic              locked,
  output logic [3:0]        slip_pos
);

  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(TOKEN_RUN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        slip;
  logic [3:0]        slip_nx;
  logic [3:0]        slip_inc;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  run_nx;
  logic [CNT_W-1:0]  tmo;
  logic [CNT_W-1:0]  tmo_nx;
  logic [CNT_W-1:0]  gap;
  logic [CNT_W-1:0]  gap_nx;
  logic [TMDS_W-1:0] sym_prev;
  logic [TMDS_W-1:0] w;
  logic [TMDS_W-1:0] w_r;
  logic [2*TMDS_W-1:0] cat;
  logic              tok;
  logic [1:0]        ctl;
  logic [7:0]        data;
  out_t              o_r;
  out_t              o_nx;

  // sym_prev holds the older bits, so it sits low
  assign cat = {sym_in, sym_prev};
  assign w   = TMDS_W'(cat >> slip);

  assign slip_inc =
    (slip == 4'd9) ? 4'd0 : slip + 4'd1;

  tmds_symbol_decode u_dec (
    .sym      (w_r),
    .is_token (tok),
    .ctl      (ctl),
    .data     (data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      slip     <= '0;
      run_cnt  <= '0;
      tmo      <= '0;
      gap      <= '0;
      sym_prev <= '0;
      w_r      <= '0;
      o_r      <= '0;
    end else begin
      state    <= state_nx;
      slip     <= slip_nx;
      run_cnt  <= run_nx;
      tmo      <= tmo_nx;
      gap      <= gap_nx;
      sym_prev <= sym_in;
      w_r      <= w;
      o_r      <= o_nx;
    end
  end

  always_comb begin
    state_nx = state;
    slip_nx  = slip;
    run_nx   = run_cnt;
    tmo_nx   = tmo;
    gap_nx   = gap;
    if (resync) begin
      state_nx = SEARCH;
      slip_nx  = slip_inc;
      run_nx   = '0;
      tmo_nx   = '0;
      gap_nx   = '0;
    end else begin
      unique case (state)
        SEARCH: begin
          tmo_nx = tmo + 1'b1;
          run_nx = tok ? run_cnt + 1'b1 : '0;
          if (tok && run_cnt == RUN_LAST) begin
            state_nx = LOCKED;
            run_nx   = '0;
            tmo_nx   = '0;
            gap_nx   = '0;
          end else if (tmo == TMO_LAST) begin
            slip_nx = slip_inc;
            tmo_nx  = '0;
            run_nx  = '0;
          end
        end
        LOCKED: begin
          if (tok) begin
            gap_nx = '0;
          end else if (gap == GAP_LAST) begin
            state_nx = SEARCH;
            slip_nx  = slip_inc;
            run_nx   = '0;
            tmo_nx   = '0;
            gap_nx   = '0;
          end else begin
            gap_nx = gap + 1'b1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  // Data and sync each hold while the other kind is shown
  always_comb begin
    o_nx        = o_r;
    o_nx.locked = (state == LOCKED);
    if (state == LOCKED) begin
      if (tok) begin
        o_nx.de   = 1'b0;
        o_nx.sync = ctl;
      end else begin
        o_nx.de = 1'b1;
        o_nx.d  = data;
      end
    end else begin
      o_nx.de   = 1'b0;
      o_nx.sync = 2'd0;
      o_nx.d    = 8'd0;
    end
  end

  assign d_out    = o_r.d;
  assign sync_out = o_r.sync;
  assign de       = o_r.de;
  assign locked   = o_r.locked;
  assign slip_pos = slip;

endmodule

// File: tb/tb_tmds_decode_align.sv
// Randomised bench for tmds_decode_align
// against a bit-stream reference model.
module tb_tmds_decode_align;

  localparam int TOKEN_RUN      = 12;
  localparam int SEARCH_TIMEOUT = 1024;
  localparam int LOCK_TIMEOUT   = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sym_in;
  logic       resync;
  logic [7:0] d_out;
  logic [1:0] sync_out;
  logic       de;
  logic       locked;
  logic [3:0] slip_pos;

  always #5 clk = ~clk;

  tmds_decode_align #(
    .TOKEN_RUN      (TOKEN_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sym_in   (sym_in),
    .resync   (resync),
    .d_out    (d_out),
    .sync_out (sync_out),
    .de       (de),
    .locked   (locked),
    .slip_pos (slip_pos)
  );

  logic [9:0] TOK [4] = '{
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011
  };

  int vectors = 0;
  int errors  = 0;
  bit armed   = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // ---- reference model ----
  bit         m_lk;
  int         m_slip, m_run, m_tmo, m_gap;
  logic [9:0] m_wr, m_prev;
  logic [7:0] e_d;
  logic [1:0] e_sync;
  logic       e_de, e_lk;

  function automatic int tok_idx(input logic [9:0] q);
    for (int i = 0; i < 4; i++)
      if (q == TOK[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_dec(
      input logic [9:0] q);
    logic [7:0] p, d;
    p = q[9] ? ~q[7:0] : q[7:0];
    d[0] = p[0];
    for (int i = 1; i < 8; i++) begin
      if (q[8]) d[i] = p[i] ^ p[i-1];
      else      d[i] = !(p[i] ^ p[i-1]);
    end
    return d;
  endfunction

  task automatic search_adv();
    m_lk   = 1'b0;
    m_slip = (m_slip + 1) % 10;
    m_run  = 0;
    m_tmo  = 0;
    m_gap  = 0;
  endtask

  task automatic model_edge(input logic [9:0] s,
                            input logic r,
                            input logic rs);
    int t;
    logic [9:0] w;
    bit b [20];
    if (r) begin
      m_lk = 0; m_slip = 0; m_run = 0;
      m_tmo = 0; m_gap = 0;
      m_wr = '0; m_prev = '0;
      e_d = '0; e_sync = '0;
      e_de = 0; e_lk = 0;
      return;
    end
    t = tok_idx(m_wr);
    if (m_lk) begin
      e_lk = 1'b1;
      if (t >= 0) begin
        e_de   = 1'b0;
        e_sync = 2'(t);
      end else begin
        e_de = 1'b1;
        e_d  = m_dec(m_wr);
      end
    end else begin
      e_lk = 0; e_de = 0;
      e_sync = '0; e_d = '0;
    end
    // window over the received bit order
    for (int i = 0; i < 10; i++) begin
      b[i]      = m_prev[i];
      b[i + 10] = s[i];
    end
    for (int j = 0; j < 10; j++)
      w[j] = b[m_slip + j];
    if (rs) begin
      search_adv();
    end else if (!m_lk) begin
      m_tmo++;
      m_run = (t >= 0) ? m_run + 1 : 0;
      if (t >= 0 && m_run == TOKEN_RUN) begin
        m_lk = 1; m_run = 0;
        m_gap = 0; m_tmo = 0;
      end else if (m_tmo == SEARCH_TIMEOUT) begin
        search_adv();
      end
    end else begin
      if (t >= 0) m_gap = 0;
      else if (m_gap == LOCK_TIMEOUT - 1)
        search_adv();
      else m_gap++;
    end
    m_wr   = w;
    m_prev = s;
  endtask

  // ---- transmit side: encoder + bit queue ----
  int enc_cnt;
  bit txq [$];

  function automatic logic [9:0] tmds_enc(
      input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q, b8;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++)
        qm[i] = !(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++)
        qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    b8  = qm[8] ? 1 : 0;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8],
           qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8]) enc_cnt += n1q - n0q;
      else       enc_cnt += n0q - n1q;
    end else if ((enc_cnt > 0 && n1q > n0q) ||
                 (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * b8 + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * (1 - b8) + n1q - n0q;
    end
    return q;
  endfunction

  task automatic push_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++)
      txq.push_back(w[i]);
  endtask

  task automatic push_delay(input int n);
    for (int i = 0; i < n; i++)
      txq.push_back(1'($urandom));
  endtask

  task automatic gen_tok(input int idx,
                         input int n);
    for (int i = 0; i < n; i++)
      push_word(TOK[idx]);
  endtask

  task automatic gen_data(input int n);
    for (int i = 0; i < n; i++)
      push_word(tmds_enc(8'($urandom)));
  endtask

  // ---- drive ----
  task automatic step(input logic [9:0] s,
                      input logic r,
                      input logic rs);
    sym_in = s;
    rst    = r;
    resync = rs;
    @(posedge clk);
    #1;
    model_edge(s, r, rs);
  endtask

  task automatic drive_all();
    logic [9:0] w;
    while (txq.size() >= 10) begin
      for (int i = 0; i < 10; i++)
        w[i] = txq.pop_front();
      step(w, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    step('0, 1'b1, 1'b0);
    txq.delete();
    enc_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("d_out",    d_out,    e_d);
      chk("sync_out", sync_out, e_sync);
      chk("de",       de,       e_de);
      chk("locked",   locked,   e_lk);
      chk("slip_pos", slip_pos, m_slip);
    end
  end

  int dly;
  int need;

  initial begin
    sym_in = '0;
    rst    = 1'b1;
    resync = 1'b0;
    enc_cnt = 0;

    // pin the model
    chk("pin_dec_00",
        m_dec(10'b0100000000), 8'h00);
    chk("pin_dec_ff",
        m_dec(10'b1000000000), 8'hFF);
    chk("pin_tok_11",
        tok_idx(10'b1010101011), 3);

    do_reset();
    armed = 1'b1;
    chk("rst_locked", locked, 0);
    chk("rst_slip", slip_pos, 0);

    // aligned token run locks
    for (int i = 0; i < TOKEN_RUN + 2; i++)
      step(TOK[0], 1'b0, 1'b0);
    chk("t1_not_yet", locked, 0);
    step(TOK[0], 1'b0, 1'b0);
    chk("t1_locked", locked, 1);
    chk("t1_slip", slip_pos, 0);
    chk("t1_sync", sync_out, 2'b00);
    chk("t1_de", de, 0);
    for (int i = 0; i < 5; i++)
      step(TOK[0], 1'b0, 1'b0);

    // two data words, 2 clk latency
    step(10'b0100000000, 1'b0, 1'b0);
    step(10'b1000000000, 1'b0, 1'b0);
    step(TOK[0], 1'b0, 1'b0);
    chk("t3_de0", de, 1);
    chk("t3_d00", d_out, 8'h00);
    step(TOK[0], 1'b0, 1'b0);
    chk("t3_de1", de, 1);
    chk("t3_dff", d_out, 8'hFF);
    step(TOK[0], 1'b0, 1'b0);
    chk("t3_tok_de", de, 0);
    chk("t3_hold", d_out, 8'hFF);
    step(TOK[0], 1'b0, 1'b0);

    // lock loss after LOCK_TIMEOUT data words
    enc_cnt = 0;
    for (int i = 0; i < LOCK_TIMEOUT + 2; i++)
      step(tmds_enc(8'($urandom)), 1'b0, 1'b0);
    chk("t4_still", locked, 1);
    chk("t4_slip", slip_pos, 1);
    step(tmds_enc(8'($urandom)), 1'b0, 1'b0);
    chk("t4_lost", locked, 0);

    // walk slip to 9, lock there, resync
    for (int i = 0; i < 8; i++)
      step('0, 1'b0, 1'b1);
    chk("t5_slip9", slip_pos, 9);
    txq.delete();
    push_delay(9);
    gen_tok(1, 30);
    drive_all();
    chk("t5_locked", locked, 1);
    step(TOK[1], 1'b0, 1'b1);
    step(TOK[1], 1'b0, 1'b0);
    chk("t5_unlock", locked, 0);
    chk("t5_wrap", slip_pos, 0);

    // reset while locked
    do_reset();
    gen_tok(2, 20);
    push_word(tmds_enc(8'hA5));
    gen_tok(2, 3);
    drive_all();
    chk("t6_pre_d", d_out, 8'hA5);
    chk("t6_pre_s", sync_out, 2'b10);
    step(TOK[2], 1'b1, 1'b0);
    chk("t6_locked", locked, 0);
    chk("t6_de", de, 0);
    chk("t6_d", d_out, 0);
    chk("t6_sync", sync_out, 0);
    chk("t6_slip", slip_pos, 0);

    // token/data bursts delayed 3 bits
    do_reset();
    push_delay(3);
    for (int k = 0; k < 5; k++) begin
      gen_tok(3, 160);
      gen_data(640);
    end
    drive_all();
    chk("t2_slip", slip_pos, 3);
    chk("t2_locked", locked, 1);
    chk("t2_sync", sync_out, 2'b11);

    // loopback with random bit delay
    for (int r = 0; r < 3; r++) begin
      do_reset();
      dly  = $urandom_range(0, 9);
      need = (dly + 1) * SEARCH_TIMEOUT + 1200;
      push_delay(dly);
      while (txq.size() < need * 10) begin
        gen_tok($urandom_range(0, 3),
                $urandom_range(16, 40));
        gen_data($urandom_range(50, 400));
      end
      gen_tok($urandom_range(0, 3), 20);
      drive_all();
      chk("lb_slip", slip_pos, dly);
      chk("lb_locked", locked, 1);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
